// File: rtl/intrude_cycle_sequencer.sv
// rtl/intrude_cycle_sequencer.sv - round-robin intrude bus cycle sequencer (READ/WRITE/RMW)
//
// Purpose: arbitrates NCH intrude requesters round-robin and runs one bus
// cycle per grant: READ, WRITE or masked READ-MODIFY-WRITE. Strobes have
// programmable wait states and a TRUDY stretch input. All outputs registered.
//
// Ports:
//   CLK, RESET        clock, asynchronous active-high reset
//   REQ[NCH]          per-channel level request, held until its ACK
//   MODE[2*NCH]       per-channel mode: 00 READ, 01 WRITE, 10 RMW, 11 READ
//   ADDR/WDATA/WMASK  per-channel address, write data, RMW bit mask
//   RD_WAIT, WR_WAIT  extra wait cycles for read / write strobes
//   TRUDY             freezes the wait counter while high in RD/WR
//   BUS_DIN           read data from memory
//   BUS_RD, BUS_WR    read / write strobes
//   BUS_ADDR, BUS_DOUT registered address and write data
//   ACK[NCH]          one-cycle one-hot completion pulse
//   RDATA             captured read data
//   BUSY              high whenever the sequencer is not idle
module intrude_cycle_sequencer #(
  parameter int NCH   = 4,
  parameter int AW    = 20,
  parameter int DW    = 16,
  parameter int WAITW = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [NCH-1:0]    REQ,
  input  logic [2*NCH-1:0]  MODE,
  input  logic [AW*NCH-1:0] ADDR,
  input  logic [DW*NCH-1:0] WDATA,
  input  logic [DW*NCH-1:0] WMASK,
  input  logic [WAITW-1:0]  RD_WAIT,
  input  logic [WAITW-1:0]  WR_WAIT,
  input  logic              TRUDY,
  input  logic [DW-1:0]     BUS_DIN,
  output logic              BUS_RD,
  output logic              BUS_WR,
  output logic [AW-1:0]     BUS_ADDR,
  output logic [DW-1:0]     BUS_DOUT,
  output logic [NCH-1:0]    ACK,
  output logic [DW-1:0]     RDATA,
  output logic              BUSY
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_TURN = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    rr_q, rr_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic             rmw_q, rmw_d;
  logic [WAITW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    wmask_q, wmask_d;
  logic [AW-1:0]    bus_addr_q, bus_addr_d;
  logic [DW-1:0]    bus_dout_q, bus_dout_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [NCH-1:0]   ack_q, ack_d;
  logic             bus_rd_q, bus_rd_d;
  logic             bus_wr_q, bus_wr_d;
  logic             busy_q, busy_d;

  // Round-robin search: first requesting channel at or above rr_q, wrapping.
  logic found;
  int   win_idx;

  always_comb begin
    int cand;
    cand    = 0;
    found   = 1'b0;
    win_idx = 0;
    for (int i = 0; i < NCH; i++) begin
      cand = (int'(rr_q) + i) % NCH;
      if (!found && REQ[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  logic [1:0] win_mode;
  assign win_mode = MODE[win_idx*2 +: 2];

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    ch_d       = ch_q;
    rmw_d      = rmw_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    bus_addr_d = bus_addr_q;
    bus_dout_d = bus_dout_q;
    rdata_d    = rdata_q;
    ack_d      = '0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          ch_d       = CW'(win_idx);
          rr_d       = CW'((win_idx + 1) % NCH);
          bus_addr_d = ADDR[win_idx*AW +: AW];
          wdata_d    = WDATA[win_idx*DW +: DW];
          wmask_d    = WMASK[win_idx*DW +: DW];
          rmw_d      = (win_mode == 2'b10);
          if (win_mode == 2'b01) begin
            state_d    = S_WR;
            cnt_d      = WR_WAIT;
            bus_dout_d = WDATA[win_idx*DW +: DW];
          end else begin
            // READ, RMW and the reserved code all start with a read strobe.
            state_d = S_RD;
            cnt_d   = RD_WAIT;
          end
        end
      end
      S_RD: begin
        if (!TRUDY) begin
          if (cnt_q == '0) begin
            rdata_d = BUS_DIN;
            state_d = rmw_q ? S_TURN : S_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_TURN: begin
        // rdata_q already holds the value captured at the end of the read.
        bus_dout_d = (rdata_q & ~wmask_q) | (wdata_q & wmask_q);
        cnt_d      = WR_WAIT;
        state_d    = S_WR;
      end
      S_WR: begin
        if (!TRUDY) begin
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered copies of the next-state decode, so they are
    // valid for exactly the cycles spent in the corresponding state.
    if (state_d == S_DONE) begin
      ack_d[ch_d] = 1'b1;
    end
    bus_rd_d = (state_d == S_RD);
    bus_wr_d = (state_d == S_WR);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      ch_q       <= '0;
      rmw_q      <= 1'b0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      bus_addr_q <= '0;
      bus_dout_q <= '0;
      rdata_q    <= '0;
      ack_q      <= '0;
      bus_rd_q   <= 1'b0;
      bus_wr_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      ch_q       <= ch_d;
      rmw_q      <= rmw_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      bus_addr_q <= bus_addr_d;
      bus_dout_q <= bus_dout_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      bus_rd_q   <= bus_rd_d;
      bus_wr_q   <= bus_wr_d;
      busy_q     <= busy_d;
    end
  end

  assign BUS_RD   = bus_rd_q;
  assign BUS_WR   = bus_wr_q;
  assign BUS_ADDR = bus_addr_q;
  assign BUS_DOUT = bus_dout_q;
  assign ACK      = ack_q;
  assign RDATA    = rdata_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_intrude_cycle_sequencer.sv
// tb/tb_intrude_cycle_sequencer.sv - directed self-checking bench for intrude_cycle_sequencer
module tb_intrude_cycle_sequencer;

  localparam int NCH   = 4;
  localparam int AW    = 20;
  localparam int DW    = 16;
  localparam int WAITW = 3;

  logic              CLK;
  logic              RESET;
  logic [NCH-1:0]    REQ;
  logic [2*NCH-1:0]  MODE;
  logic [AW*NCH-1:0] ADDR;
  logic [DW*NCH-1:0] WDATA;
  logic [DW*NCH-1:0] WMASK;
  logic [WAITW-1:0]  RD_WAIT;
  logic [WAITW-1:0]  WR_WAIT;
  logic              TRUDY;
  logic [DW-1:0]     BUS_DIN;
  logic              BUS_RD;
  logic              BUS_WR;
  logic [AW-1:0]     BUS_ADDR;
  logic [DW-1:0]     BUS_DOUT;
  logic [NCH-1:0]    ACK;
  logic [DW-1:0]     RDATA;
  logic              BUSY;

  intrude_cycle_sequencer #(.NCH(NCH), .AW(AW), .DW(DW), .WAITW(WAITW)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .MODE(MODE), .ADDR(ADDR),
    .WDATA(WDATA), .WMASK(WMASK), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT),
    .TRUDY(TRUDY), .BUS_DIN(BUS_DIN), .BUS_RD(BUS_RD), .BUS_WR(BUS_WR),
    .BUS_ADDR(BUS_ADDR), .BUS_DOUT(BUS_DOUT), .ACK(ACK), .RDATA(RDATA),
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int passed  = 0;
  int total   = 0;
  int overlap = 0;

  always @(negedge CLK) begin
    if (BUS_RD && BUS_WR) overlap++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Ticks until ACK is seen; TRUDY is held high for the first trudy_cycles edges after the first.
  task automatic run_to_ack(input int trudy_cycles, output int nrd, output int nwr,
                            output int ncyc, output logic [NCH-1:0] ack);
    nrd  = 0;
    nwr  = 0;
    ncyc = 0;
    ack  = '0;
    for (int i = 0; i < 64; i++) begin
      tick();
      ncyc++;
      if (BUS_RD) nrd++;
      if (BUS_WR) nwr++;
      if (ACK != '0) begin
        ack = ACK;
        break;
      end
      TRUDY = (i < trudy_cycles);
    end
    TRUDY = 1'b0;
    if (ack == '0) chk("ack_timeout", 32'(ncyc), 32'd0);
  endtask

  int nrd, nwr, ncyc;
  logic [NCH-1:0] ack;

  initial begin
    RESET   = 1'b1;
    REQ     = '0;
    MODE    = '0;
    ADDR    = '0;
    WDATA   = '0;
    WMASK   = '0;
    RD_WAIT = '0;
    WR_WAIT = '0;
    TRUDY   = 1'b0;
    BUS_DIN = '0;
    tick();
    tick();
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_rd", 32'(BUS_RD), 32'd0);
    chk("rst_wr", 32'(BUS_WR), 32'd0);
    chk("rst_ack", 32'(ACK), 32'd0);
    chk("rst_addr", 32'(BUS_ADDR), 32'd0);
    chk("rst_rdata", 32'(RDATA), 32'd0);
    RESET = 1'b0;
    tick();
    chk("idle_busy", 32'(BUSY), 32'd0);

    // T1: ch0 READ, zero waits
    ADDR[0*AW +: AW] = 20'h00100;
    MODE[1:0] = 2'b00;
    BUS_DIN   = 16'hBEEF;
    REQ       = 4'b0001;
    tick();
    chk("t1_rd_on", 32'(BUS_RD), 32'd1);
    chk("t1_addr", 32'(BUS_ADDR), 32'h00100);
    chk("t1_busy", 32'(BUSY), 32'd1);
    chk("t1_ack_early", 32'(ACK), 32'd0);
    tick();
    chk("t1_ack", 32'(ACK), 32'b0001);
    chk("t1_rd_off", 32'(BUS_RD), 32'd0);
    chk("t1_rdata", 32'(RDATA), 32'hBEEF);
    REQ = '0;
    tick();
    chk("t1_ack_clr", 32'(ACK), 32'd0);
    chk("t1_idle", 32'(BUSY), 32'd0);

    // T2: ch2 WRITE, WR_WAIT=2, TRUDY high for 2 cycles
    ADDR[2*AW +: AW]  = 20'h0ABCD;
    WDATA[2*DW +: DW] = 16'h1234;
    MODE[5:4] = 2'b01;
    WR_WAIT   = 3'd2;
    REQ       = 4'b0100;
    tick();
    chk("t2_wr_on", 32'(BUS_WR), 32'd1);
    chk("t2_dout", 32'(BUS_DOUT), 32'h1234);
    chk("t2_addr", 32'(BUS_ADDR), 32'h0ABCD);
    run_to_ack(2, nrd, nwr, ncyc, ack);
    chk("t2_wr_len", 32'(nwr + 1), 32'd5);
    chk("t2_no_rd", 32'(nrd), 32'd0);
    chk("t2_ack", 32'(ack), 32'b0100);
    chk("t2_rdata_held", 32'(RDATA), 32'hBEEF);
    REQ = '0;
    tick();
    chk("t2_ack_clr", 32'(ACK), 32'd0);

    // T3: ch1 RMW merge
    WDATA[1*DW +: DW] = 16'h00AA;
    WMASK[1*DW +: DW] = 16'h00F0;
    MODE[3:2] = 2'b10;
    BUS_DIN   = 16'hFF00;
    RD_WAIT   = 3'd0;
    WR_WAIT   = 3'd0;
    REQ       = 4'b0010;
    tick();
    chk("t3_rd", 32'(BUS_RD), 32'd1);
    tick();
    chk("t3_turn_rd", 32'(BUS_RD), 32'd0);
    chk("t3_turn_wr", 32'(BUS_WR), 32'd0);
    chk("t3_rdata", 32'(RDATA), 32'hFF00);
    chk("t3_turn_busy", 32'(BUSY), 32'd1);
    tick();
    chk("t3_wr", 32'(BUS_WR), 32'd1);
    chk("t3_dout", 32'(BUS_DOUT), 32'hFFA0);
    tick();
    chk("t3_ack", 32'(ACK), 32'b0010);
    chk("t3_wr_off", 32'(BUS_WR), 32'd0);
    REQ = '0;
    tick();

    // T5: reset in the middle of a ch3 WRITE
    WDATA[3*DW +: DW] = 16'h7777;
    MODE[7:6] = 2'b01;
    WR_WAIT   = 3'd3;
    REQ       = 4'b1000;
    tick();
    chk("t5_wr_on", 32'(BUS_WR), 32'd1);
    tick();
    RESET = 1'b1;
    #1;
    chk("t5_wr_drop", 32'(BUS_WR), 32'd0);
    chk("t5_busy", 32'(BUSY), 32'd0);
    chk("t5_ack", 32'(ACK), 32'd0);
    REQ = '0;
    tick();
    chk("t5_ack_after", 32'(ACK), 32'd0);
    RESET = 1'b0;
    tick();

    // T4: all channels requesting, round-robin from 0 after reset
    MODE    = '0;
    RD_WAIT = 3'd0;
    for (int k = 0; k < NCH; k++) ADDR[k*AW +: AW] = 20'h10000 + 20'(k);
    REQ = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      run_to_ack(0, nrd, nwr, ncyc, ack);
      chk($sformatf("t4_ack%0d", g), 32'(ack), 32'(1) << (g % 4));
      chk($sformatf("t4_addr%0d", g), 32'(BUS_ADDR), 32'h10000 + 32'(g % 4));
      chk($sformatf("t4_cyc%0d", g), 32'(ncyc), (g == 0) ? 32'd2 : 32'd3);
    end
    REQ = '0;
    tick();

    // T6: ch1 reserved mode behaves as READ; REQ/MODE/ADDR changes mid-cycle ignored
    ADDR[1*AW +: AW] = 20'h54321;
    MODE[3:2] = 2'b11;
    RD_WAIT   = 3'd2;
    BUS_DIN   = 16'h5A5A;
    REQ       = 4'b0010;
    tick();
    chk("t6_rd_on", 32'(BUS_RD), 32'd1);
    REQ = '0;
    MODE[3:2] = 2'b01;
    ADDR[1*AW +: AW] = 20'h11111;
    run_to_ack(0, nrd, nwr, ncyc, ack);
    chk("t6_rd_len", 32'(nrd + 1), 32'd3);
    chk("t6_no_wr", 32'(nwr), 32'd0);
    chk("t6_ack", 32'(ack), 32'b0010);
    chk("t6_addr", 32'(BUS_ADDR), 32'h54321);
    chk("t6_rdata", 32'(RDATA), 32'h5A5A);
    tick();
    chk("t6_idle", 32'(BUSY), 32'd0);
    chk("t6_ack_clr", 32'(ACK), 32'd0);
    tick();
    chk("t6_stay_idle", 32'(BUSY), 32'd0);

    chk("no_overlap", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
